conv_1x1_weight_sched: RTL and testbench

//  Sequences weight delivery for the 1x1 convolution datapath (conv_1x1_top_xx weight port).
//  Per output channel: reads CHANNEL_NUM_IN weights from a fixed-latency weight ROM/BRAM, streams them
//  on valid_weight_out/weight_out, then waits for the datapath to finish the image pass before the next

---
 rtl/conv_1x1_weight_sched.sv | 142 ++++++++++++++
 tb/tb_conv_1x1_weight_sched.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_1x1_weight_sched.sv
// Per-output-channel weight burst sequencer between a fixed-latency weight memory and the 1x1 conv engine.
// Weights appear MEM_LATENCY cycles after their read strobe; the next burst waits for the datapath's pass_done.
module conv_1x1_weight_sched #(
    parameter int DATA_WIDTH      = 32,
    parameter int CHANNEL_NUM_IN  = 256,
    parameter int CHANNEL_NUM_OUT = 512,
    parameter int ADDR_WIDTH      = 17,
    parameter int BASE_ADDR       = 0,
    parameter int MEM_LATENCY     = 2,
    parameter int OC_WIDTH        = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  pass_done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  valid_weight_out,
    output logic [DATA_WIDTH-1:0] weight_out,
    output logic [OC_WIDTH-1:0]   oc_idx,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_MAX   = (CHANNEL_NUM_IN > MEM_LATENCY) ? CHANNEL_NUM_IN : MEM_LATENCY;
    localparam int CNT_WIDTH = $clog2(CNT_MAX + 1);

    localparam logic [CNT_WIDTH-1:0]  CIN_LAST  = CNT_WIDTH'(CHANNEL_NUM_IN - 1);
    localparam logic [CNT_WIDTH-1:0]  LAT_LAST  = CNT_WIDTH'(MEM_LATENCY - 1);
    localparam logic [OC_WIDTH-1:0]   OC_LAST   = OC_WIDTH'(CHANNEL_NUM_OUT - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_BASE = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_WAIT_PASS,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [OC_WIDTH-1:0]    oc_q, oc_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   pend_q, pend_d;
    logic [MEM_LATENCY-1:0] pipe_q, pipe_d;
    logic [DATA_WIDTH-1:0]  hold_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        oc_d      = oc_q;
        addr_d    = addr_q;
        pend_d    = pend_q;
        mem_rd_en = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    oc_d    = '0;
                    addr_d  = ADDR_BASE;
                    pend_d  = 1'b0;
                end
            end
            // Bursts are back-to-back in address order, so a running address equals BASE + oc*CIN + ci.
            S_LOAD: begin
                mem_rd_en = 1'b1;
                addr_d    = addr_q + ADDR_WIDTH'(1);
                if (pass_done) pend_d = 1'b1;
                if (cnt_q == CIN_LAST) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            S_DRAIN: begin
                if (pass_done) pend_d = 1'b1;
                if (cnt_q == LAT_LAST) begin
                    state_d = S_WAIT_PASS;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            S_WAIT_PASS: begin
                if (pass_done || pend_q) begin
                    pend_d = 1'b0;
                    if (oc_q == OC_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        oc_d    = oc_q + OC_WIDTH'(1);
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                oc_d    = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read-valid pipe mirrors the memory latency; clearing it on reset drops in-flight returns.
    always_comb begin
        pipe_d    = pipe_q << 1;
        pipe_d[0] = mem_rd_en;
    end

    assign mem_addr         = mem_rd_en ? addr_q : '0;
    assign valid_weight_out = pipe_q[MEM_LATENCY-1];
    assign weight_out       = valid_weight_out ? mem_rd_data : hold_q;
    assign oc_idx           = oc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            oc_q    <= '0;
            addr_q  <= '0;
            pend_q  <= 1'b0;
            pipe_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            oc_q    <= oc_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
            pipe_q  <= pipe_d;
            if (valid_weight_out) hold_q <= mem_rd_data;
        end
    end

endmodule

// File: tb/tb_conv_1x1_weight_sched.sv
// Bench for conv_1x1_weight_sched: two instances (CIN=4/COUT=3/LAT=2 and CIN=4/COUT=1/LAT=1), each on a
// fixed-latency memory model, compared cycle by cycle against a schedule computed from burst timestamps.
module tb_conv_1x1_weight_sched;

    localparam int CIN  = 4;
    localparam int BASE = 16;
    localparam int MAXC = 256;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic pass_done = 1'b0;

    logic        a_rd_en, a_vld, a_busy, a_done;
    logic [16:0] a_addr;
    logic [31:0] a_rd_data, a_w;
    logic [1:0]  a_oc;

    logic        b_rd_en, b_vld, b_busy, b_done;
    logic [16:0] b_addr;
    logic [31:0] b_rd_data, b_w;
    logic [0:0]  b_oc;

    logic        a_p0_en = 1'b0, a_p1_en = 1'b0, b_p_en = 1'b0;
    logic [16:0] a_p0_addr = '0, a_p1_addr = '0, b_p_addr = '0;
    logic [31:0] junk = '0;
    logic [31:0] salt = '0;
    logic [31:0] last_w = '0;

    int n_chk = 0;
    int n_fail = 0;

    bit          e_rd[MAXC], e_vld[MAXC], e_busy[MAXC], e_done[MAXC], d_st[MAXC], d_pd[MAXC];
    logic [31:0] e_addr[MAXC], e_dat[MAXC], e_w[MAXC];
    int          e_oc[MAXC];

    always #5 clk = ~clk;

    conv_1x1_weight_sched #(
        .DATA_WIDTH(32), .CHANNEL_NUM_IN(CIN), .CHANNEL_NUM_OUT(3),
        .ADDR_WIDTH(17), .BASE_ADDR(BASE), .MEM_LATENCY(2)
    ) dut_a (
        .clk(clk), .reset(reset), .start(start), .pass_done(pass_done),
        .mem_rd_en(a_rd_en), .mem_addr(a_addr), .mem_rd_data(a_rd_data),
        .valid_weight_out(a_vld), .weight_out(a_w), .oc_idx(a_oc),
        .busy(a_busy), .done(a_done)
    );

    conv_1x1_weight_sched #(
        .DATA_WIDTH(32), .CHANNEL_NUM_IN(CIN), .CHANNEL_NUM_OUT(1),
        .ADDR_WIDTH(17), .BASE_ADDR(BASE), .MEM_LATENCY(1)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start), .pass_done(pass_done),
        .mem_rd_en(b_rd_en), .mem_addr(b_addr), .mem_rd_data(b_rd_data),
        .valid_weight_out(b_vld), .weight_out(b_w), .oc_idx(b_oc),
        .busy(b_busy), .done(b_done)
    );

    // Fixed-latency memories: data = address ^ salt, garbage whenever no read is returning.
    always @(posedge clk) begin
        a_p0_en   <= a_rd_en;
        a_p0_addr <= a_addr;
        a_p1_en   <= a_p0_en;
        a_p1_addr <= a_p0_addr;
        b_p_en    <= b_rd_en;
        b_p_addr  <= b_addr;
        junk      <= $urandom;
    end
    assign a_rd_data = a_p1_en ? (32'(a_p1_addr) ^ salt) : junk;
    assign b_rd_data = b_p_en ? (32'(b_p_addr) ^ salt) : junk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv, input int c);
        n_chk++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s cycle %0d: got %0h expected %0h", tag, c, obs, expv);
        end
    endtask

    task automatic do_reset();
        #1;
        reset = 1'b1;
        start = 1'b0;
        pass_done = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_rd_en", 32'(a_rd_en), 32'd0, 0);
        chk("rst_a_addr", 32'(a_addr), 32'd0, 0);
        chk("rst_a_valid", 32'(a_vld), 32'd0, 0);
        chk("rst_a_weight", a_w, 32'd0, 0);
        chk("rst_a_oc", 32'(a_oc), 32'd0, 0);
        chk("rst_a_busy", 32'(a_busy), 32'd0, 0);
        chk("rst_a_done", 32'(a_done), 32'd0, 0);
        chk("rst_b_rd_en", 32'(b_rd_en), 32'd0, 0);
        chk("rst_b_valid", 32'(b_vld), 32'd0, 0);
        chk("rst_b_weight", b_w, 32'd0, 0);
        chk("rst_b_busy", 32'(b_busy), 32'd0, 0);
        chk("rst_b_done", 32'(b_done), 32'd0, 0);
        @(posedge clk);
        last_w = '0;
    endtask

    // Cycle 0 carries the start pulse. Burst k reads at S_k.., weights land ml cycles later,
    // WAIT_PASS is entered at W_k = S_k+CIN+ml, and the next burst (or DONE) follows max(P_k,W_k)+1.
    task automatic run_layer(input int sel, input int ml, input int cout, input bit rst_mid);
        int s, w, w0, p, nxt, d, len, rc, r;
        logic [31:0] a, last;
        logic        o_rd, o_vld, o_busy, o_done;
        logic [31:0] o_addr, o_w, o_oc;
        for (int c = 0; c < MAXC; c++) begin
            e_rd[c] = 1'b0; e_vld[c] = 1'b0; e_busy[c] = 1'b0; e_done[c] = 1'b0;
            d_st[c] = 1'b0; d_pd[c] = 1'b0;
            e_addr[c] = '0; e_dat[c] = '0; e_w[c] = '0; e_oc[c] = 0;
        end
        d_st[0] = 1'b1;
        d_pd[0] = 1'b1;
        s = 1;
        rc = -1;
        w0 = 0;
        for (int k = 0; k < cout; k++) begin
            for (int i = 0; i < CIN; i++) begin
                a = 32'(BASE + k * CIN + i);
                e_rd[s+i] = 1'b1;
                e_addr[s+i] = a;
                e_vld[s+i+ml] = 1'b1;
                e_dat[s+i+ml] = a ^ salt;
            end
            w = s + CIN + ml;
            if (k == 0) w0 = w;
            r = int'($urandom_range(CIN + ml + 5, 0));
            p = w + r - (CIN + ml);
            d_pd[p] = 1'b1;
            if (p + 2 < w) d_pd[p+2] = 1'b1;
            if (rst_mid && k == 1) rc = s + 1;
            nxt = ((p > w) ? p : w) + 1;
            for (int c = s; c < nxt; c++) begin
                e_busy[c] = 1'b1;
                e_oc[c] = k;
            end
            s = nxt;
        end
        d = s;
        e_done[d] = 1'b1;
        e_busy[d] = 1'b1;
        e_oc[d] = cout - 1;
        d_pd[d] = 1'b1;
        d_pd[d+1] = 1'b1;
        d_st[w0] = 1'b1;
        for (int j = 0; j < 3; j++) d_st[$urandom_range(d, 1)] = 1'b1;
        len = d + 3;
        if (rc >= 0) begin
            for (int c = rc + 1; c < MAXC; c++) begin
                e_rd[c] = 1'b0; e_vld[c] = 1'b0; e_busy[c] = 1'b0; e_done[c] = 1'b0;
                d_st[c] = 1'b0; d_pd[c] = 1'b0; e_oc[c] = 0;
            end
            len = rc + ml + 4;
        end
        last = last_w;
        for (int c = 0; c < len; c++) begin
            if (rc >= 0 && c == rc + 1) last = '0;
            if (e_vld[c]) last = e_dat[c];
            e_w[c] = last;
        end
        last_w = last;

        for (int c = 0; c < len; c++) begin
            #1;
            start = d_st[c];
            pass_done = d_pd[c];
            reset = (c == rc);
            @(negedge clk);
            if (sel == 0) begin
                o_rd = a_rd_en; o_addr = 32'(a_addr); o_vld = a_vld; o_w = a_w;
                o_oc = 32'(a_oc); o_busy = a_busy; o_done = a_done;
            end else begin
                o_rd = b_rd_en; o_addr = 32'(b_addr); o_vld = b_vld; o_w = b_w;
                o_oc = 32'(b_oc); o_busy = b_busy; o_done = b_done;
            end
            chk("mem_rd_en", 32'(o_rd), 32'(e_rd[c]), c);
            if (e_rd[c]) chk("mem_addr", o_addr, e_addr[c], c);
            chk("valid_weight_out", 32'(o_vld), 32'(e_vld[c]), c);
            chk("weight_out", o_w, e_w[c], c);
            chk("oc_idx", o_oc, 32'(e_oc[c]), c);
            chk("busy", 32'(o_busy), 32'(e_busy[c]), c);
            chk("done", 32'(o_done), 32'(e_done[c]), c);
            @(posedge clk);
        end
        #1;
        start = 1'b0;
        pass_done = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        salt = $urandom;
        do_reset();
        run_layer(0, 2, 3, 1'b0);
        run_layer(0, 2, 3, 1'b0);
        run_layer(0, 2, 3, 1'b1);
        run_layer(0, 2, 3, 1'b0);
        do_reset();
        run_layer(1, 1, 1, 1'b0);
        run_layer(1, 1, 1, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
